// File: rtl/bus_mem_responder_if.sv
// Request/handshake side of the shared scratch-memory bus.
// The initiator drives the request fields; the responder reports
// readiness and marks the cycles in which it is driving read data.
interface bus_mem_responder_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  sel;
   logic                  w_en;
   logic [ADDR_WIDTH-1:0] address_bus;
   logic                  ready;
   logic                  rd_valid;

   modport master (
      output sel, w_en, address_bus,
      input  ready, rd_valid
   );

   modport slave (
      input  sel, w_en, address_bus,
      output ready, rd_valid
   );
endinterface

// File: rtl/bus_mem_responder.sv
// Scratch-memory responder for the shared sel/w_en/address/data bus.
// After reset it zeroes every word (INIT) before accepting traffic (RUN).
// Writes land on the sampling edge; reads return through a READ_LAT-deep
// pipeline and are driven onto the tristate data_bus for one cycle each.
// A return that would collide with a write on the bus is dropped.
// err is sticky, and both access counters saturate.
module bus_mem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int READ_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   bus_mem_responder_if.slave    bus,
   inout  wire  [DATA_WIDTH-1:0] data_bus,
   output logic                  err,
   output logic [15:0]           wr_count,
   output logic [15:0]           rd_count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [15:0]           CNT_MAX   = 16'hFFFF;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0] clr_ptr_r, clr_ptr_nxt_s;
   logic                  ready_r;
   logic                  err_r;
   logic [15:0]           wr_count_r, rd_count_r;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic                  mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_addr_s;
   logic [DATA_WIDTH-1:0] mem_wdata_s;

   logic                  in_range_s, wr_cycle_s;
   logic                  wr_acc_s, rd_acc_s, oob_s, init_sel_s, drop_s;
   logic [DATA_WIDTH-1:0] rd_word_s;

   // Stage 0 is loaded on the request edge; the top stage drives the bus.
   logic [READ_LAT-1:0]                 pipe_vld_r, shift_vld_s, pipe_vld_nxt_s;
   logic [READ_LAT-1:0][DATA_WIDTH-1:0] pipe_dat_r, shift_dat_s;

   // Next-state, memory write port and access classification.
   always_comb begin
      state_nxt_s   = state_r;
      clr_ptr_nxt_s = clr_ptr_r;
      mem_we_s      = 1'b0;
      mem_addr_s    = bus.address_bus;
      mem_wdata_s   = data_bus;
      wr_acc_s      = 1'b0;
      rd_acc_s      = 1'b0;
      oob_s         = 1'b0;
      init_sel_s    = 1'b0;
      in_range_s    = ({1'b0, bus.address_bus} < DEPTH_EXT);
      wr_cycle_s    = bus.sel & bus.w_en;
      case (state_r)
         ST_INIT: begin
            mem_we_s      = 1'b1;
            mem_addr_s    = clr_ptr_r;
            mem_wdata_s   = {DATA_WIDTH{1'b0}};
            clr_ptr_nxt_s = clr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            init_sel_s    = bus.sel;
            if (clr_ptr_r == LAST_ADDR) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_INIT;
            end
         end
         ST_RUN: begin
            wr_acc_s = wr_cycle_s & in_range_s;
            rd_acc_s = bus.sel & ~bus.w_en;
            oob_s    = bus.sel & ~in_range_s;
            mem_we_s = wr_acc_s;
         end
         default: begin
            state_nxt_s = ST_INIT;
         end
      endcase
   end

   // Read word fetch and pipeline shift, dropping a return that meets a write.
   always_comb begin
      if (in_range_s) begin
         rd_word_s = mem_r[bus.address_bus];
      end else begin
         rd_word_s = {DATA_WIDTH{1'b0}};
      end
      shift_vld_s    = READ_LAT'({pipe_vld_r, rd_acc_s});
      shift_dat_s    = (READ_LAT * DATA_WIDTH)'({pipe_dat_r, rd_word_s});
      drop_s         = shift_vld_s[READ_LAT-1] & wr_cycle_s;
      pipe_vld_nxt_s = shift_vld_s;
      pipe_vld_nxt_s[READ_LAT-1] = shift_vld_s[READ_LAT-1] & ~wr_cycle_s;
   end

   // Clear sequencer state, clear pointer and ready flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_INIT;
         clr_ptr_r <= {ADDR_WIDTH{1'b0}};
         ready_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         clr_ptr_r <= clr_ptr_nxt_s;
         ready_r   <= (state_nxt_s == ST_RUN);
      end
   end

   // Read return pipeline; reset flushes it and releases the bus at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld_r <= {READ_LAT{1'b0}};
         pipe_dat_r <= {(READ_LAT * DATA_WIDTH){1'b0}};
      end else begin
         pipe_vld_r <= pipe_vld_nxt_s;
         pipe_dat_r <= shift_dat_s;
      end
   end

   // Saturating access counters and the sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count_r <= 16'h0000;
         rd_count_r <= 16'h0000;
         err_r      <= 1'b0;
      end else begin
         if (wr_acc_s && (wr_count_r != CNT_MAX)) begin
            wr_count_r <= wr_count_r + 16'h0001;
         end
         if (rd_acc_s && (rd_count_r != CNT_MAX)) begin
            rd_count_r <= rd_count_r + 16'h0001;
         end
         if (init_sel_s || oob_s || drop_s) begin
            err_r <= 1'b1;
         end
      end
   end

   // Memory array: clear writes during INIT, bus writes during RUN.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_addr_s] <= mem_wdata_s;
      end
   end

   assign data_bus     = pipe_vld_r[READ_LAT-1] ? pipe_dat_r[READ_LAT-1] : {DATA_WIDTH{1'bz}};
   assign bus.rd_valid = pipe_vld_r[READ_LAT-1];
   assign bus.ready    = ready_r;
   assign err          = err_r;
   assign wr_count     = wr_count_r;
   assign rd_count     = rd_count_r;

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
Responder end of the shared sel/w_en/address_bus/data_bus memory interface that the MAC engines use as initiators. It holds a word-addressed scratch memory, accepts single-cycle writes, and returns pipelined reads by driving the tristate data_bus. After reset it self-clears its contents before it accepts traffic. It also exposes sticky error and access-count status so benches and the top level can check bus discipline.

Parameters:
ADDR_WIDTH, 8, address_bus width
DATA_WIDTH, 32, data_bus and word width
DEPTH, 256, number of words implemented; legal addresses are 0..DEPTH-1, and DEPTH must be <= 2^ADDR_WIDTH
READ_LAT, 1, read latency in clock edges, counted from the request-sampling edge; legal range 1..4

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
sel  input  1  bus select from the current initiator
w_en  input  1  1 = write, 0 = read; only meaningful while sel=1
address_bus  input  ADDR_WIDTH  word address; this block never drives it
data_bus  inout  DATA_WIDTH  sampled on writes; driven only in read-return cycles, Z otherwise
ready  output  1  1 once the clear sequence has finished and the block is accepting accesses
rd_valid  output  1  1 in every cycle in which this block is driving data_bus
err  output  1  sticky error flag; cleared only by rst
wr_count  output  16  accepted writes, saturating at 16'hFFFF
rd_count  output  16  accepted reads, saturating at 16'hFFFF

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - ready=0, rd_valid=0, err=0, wr_count=0, rd_count=0.
  - data_bus is released to Z at once; the read pipeline is flushed.
  - FSM goes to INIT with clr_ptr=0.
- FSM, INIT state:
  - Each rising edge writes 0 to mem[clr_ptr] and increments clr_ptr.
  - After the edge that clears DEPTH-1, go to RUN; ready=1 from that edge.
  - INIT lasts exactly DEPTH edges after rst deasserts.
  - Any sel=1 seen at an edge during INIT is ignored, not counted, and sets err.
- FSM, RUN state: no exit except rst.
- Write (RUN):
  - sel=1, w_en=1 at edge N with an in-range address: mem[address_bus] <= data_bus; wr_count +1.
  - Read-after-write: a read sampled at edge N+1 to the same address returns the new data.
- Read (RUN):
  - sel=1, w_en=0 at edge N with an in-range address: rd_count +1.
  - The word is read and delivered through a READ_LAT-deep pipeline.
  - data_bus is driven and rd_valid=1 for exactly the one cycle following edge N+READ_LAT-1. With READ_LAT=1, that is the cycle right after the sampling edge.
  - Reads may be issued back-to-back; one word returns per cycle, in order.
- Out-of-range address (address_bus >= DEPTH):
  - Write: dropped, not counted, sets err.
  - Read: counted, returns 0 on the bus, sets err.
- Contention:
  - If a read return falls in a cycle where the sampled inputs show sel=1 and w_en=1, the responder does not drive. That return is dropped, rd_valid=0, and err is set. The write itself still completes.
- sel=0: no access. Pipelined returns still in flight continue to be delivered.
- Counters saturate; they never wrap.
- The clear state machine and the return pipeline are the only sequential elements besides the memory array and the counters.

Test Plan:
- Reset then idle: rst held 4 cycles, then released -> ready=0 for exactly DEPTH=256 edges, then 1. A read of address 5 afterwards returns 32'h0. data_bus is Z throughout INIT.
- Write/read, READ_LAT=1: write 32'h04030201 to addr 0 and 32'h08070605 to addr 1, then read addr 1 -> data_bus=32'h08070605 with rd_valid=1 in the cycle after the sampling edge. wr_count=2, rd_count=1, err=0.
- Pipelined reads, READ_LAT=3: reads of addrs 0,1,2 on consecutive edges (contents 10,20,30) -> returns 10,20,30 on three consecutive cycles. The first return follows sampling edge +2. data_bus is Z before and after.
- Error cases, DEPTH=200: write to addr 210, then read addr 210 -> read returns 0, err=1 and stays 1. Separately, sel=1 during INIT -> err=1 and wr_count unchanged.
- Contention, READ_LAT=2: read addr 0, then a write on the next edge (which coincides with the return cycle) -> no drive, rd_valid=0, err=1, and the write is committed.
- Reset mid-read, READ_LAT=4: assert rst 2 cycles after a read request -> data_bus goes Z immediately, no rd_valid pulse, counters 0, INIT restarts.
